approx_adder_error_monitor16: RTL and testbench

//  Downstream checker for the 16-bit approximate adders. Accepts operand

---
 rtl/approx_adder_error_monitor16_if.sv | 29 ++
 rtl/approx_adder_error_monitor16.sv | 172 +++++++++++++++++
 tb/tb_approx_adder_error_monitor16.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_adder_error_monitor16_if.sv
// Sample and report port bundle for approx_adder_error_monitor16.
// The master drives samples and accepts reports; the slave is the monitor.
interface approx_adder_error_monitor16_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 40
);
    logic               valid;
    logic               ready;
    logic [WIDTH-1:0]   add1;
    logic [WIDTH-1:0]   add2;
    logic [WIDTH:0]     approx;
    logic               report_valid;
    logic               report_ready;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [WIDTH:0]     max_ed;
    logic [ACC_W-1:0]   sum_ed;

    modport master (
        output valid, add1, add2, approx, report_ready,
        input  ready, report_valid, sample_cnt, err_cnt, max_ed, sum_ed
    );

    modport slave (
        input  valid, add1, add2, approx, report_ready,
        output ready, report_valid, sample_cnt, err_cnt, max_ed, sum_ed
    );
endinterface

// File: rtl/approx_adder_error_monitor16.sv
// Error monitor for approximate adders: windowed error count, max and
// saturating sum of |exact - approx|, published through a valid/ready report.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_ACCUM  | accepting samples until the window is full (ready high)
// ST_DRAIN  | window full, waiting for the two pipeline stages to empty
// ST_REPORT | report registers loaded, holding until the consumer accepts
module approx_adder_error_monitor16 #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 32,
    parameter int ACC_W  = 40,
    parameter int WINDOW = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    approx_adder_error_monitor16_if.slave mon
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic               s1_v_q, s1_v_d;
    logic               s2_v_q, s2_v_d;
    logic [WIDTH:0]     ed_q, ed_d;

    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [WIDTH:0]     max_ed_q, max_ed_d;
    logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;

    logic [CNT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic [CNT_W-1:0]   rpt_err_q, rpt_err_d;
    logic [WIDTH:0]     rpt_max_q, rpt_max_d;
    logic [ACC_W-1:0]   rpt_sum_q, rpt_sum_d;

    logic               accept;
    logic [WIDTH:0]     exact;
    logic [ACC_W:0]     sum_ext;

    assign mon.ready        = (state_q == ST_ACCUM);
    assign mon.report_valid = (state_q == ST_REPORT);
    assign mon.sample_cnt   = rpt_cnt_q;
    assign mon.err_cnt      = rpt_err_q;
    assign mon.max_ed       = rpt_max_q;
    assign mon.sum_ed       = rpt_sum_q;

    always_comb begin
        // Exact sum only feeds the distance, so stage 1 keeps just |exact - approx|.
        exact   = {1'b0, mon.add1} + {1'b0, mon.add2};
        ed_d    = (exact >= mon.approx) ? (exact - mon.approx) : (mon.approx - exact);
        sum_ext = {1'b0, sum_ed_q} + SUM_W'(ed_q);
        accept  = mon.valid && (state_q == ST_ACCUM);

        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        s1_v_d    = accept;
        s2_v_d    = s1_v_q;
        smp_cnt_d = smp_cnt_q;
        err_cnt_d = err_cnt_q;
        max_ed_d  = max_ed_q;
        sum_ed_d  = sum_ed_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_err_d = rpt_err_q;
        rpt_max_d = rpt_max_q;
        rpt_sum_d = rpt_sum_q;

        if (s1_v_q) begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
            if (ed_q != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (ed_q > max_ed_q) begin
                max_ed_d = ed_q;
            end
            sum_ed_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        end

        unique case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        win_cnt_d = win_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_v_q && !s2_v_q) begin
                    rpt_cnt_d = smp_cnt_q;
                    rpt_err_d = err_cnt_q;
                    rpt_max_d = max_ed_q;
                    rpt_sum_d = sum_ed_q;
                    state_d   = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (mon.report_ready) begin
                    smp_cnt_d = '0;
                    err_cnt_d = '0;
                    max_ed_d  = '0;
                    sum_ed_d  = '0;
                    state_d   = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        // Clear discards the window in flight, including any sample offered this cycle.
        if (clear_i) begin
            state_d   = ST_ACCUM;
            win_cnt_d = '0;
            s1_v_d    = 1'b0;
            s2_v_d    = 1'b0;
            ed_d      = '0;
            smp_cnt_d = '0;
            err_cnt_d = '0;
            max_ed_d  = '0;
            sum_ed_d  = '0;
            rpt_cnt_d = '0;
            rpt_err_d = '0;
            rpt_max_d = '0;
            rpt_sum_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ACCUM;
            win_cnt_q <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            ed_q      <= '0;
            smp_cnt_q <= '0;
            err_cnt_q <= '0;
            max_ed_q  <= '0;
            sum_ed_q  <= '0;
            rpt_cnt_q <= '0;
            rpt_err_q <= '0;
            rpt_max_q <= '0;
            rpt_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            ed_q      <= ed_d;
            smp_cnt_q <= smp_cnt_d;
            err_cnt_q <= err_cnt_d;
            max_ed_q  <= max_ed_d;
            sum_ed_q  <= sum_ed_d;
            rpt_cnt_q <= rpt_cnt_d;
            rpt_err_q <= rpt_err_d;
            rpt_max_q <= rpt_max_d;
            rpt_sum_q <= rpt_sum_d;
        end
    end

endmodule

// File: tb/tb_approx_adder_error_monitor16.sv
// Bench for approx_adder_error_monitor16 (WINDOW=4): directed cases plus
// random traffic, checked against a window model built from accepted samples.
module tb_approx_adder_error_monitor16;

    localparam int WIN = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] ap;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic clear_s;

    always #5 clk = ~clk;

    approx_adder_error_monitor16_if #(.WIDTH(16), .CNT_W(32), .ACC_W(40)) m ();
    approx_adder_error_monitor16_if #(.WIDTH(16), .CNT_W(32), .ACC_W(17)) ms ();

    approx_adder_error_monitor16 #(.WIDTH(16), .CNT_W(32), .ACC_W(40), .WINDOW(WIN)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .mon     (m)
    );

    approx_adder_error_monitor16 #(.WIDTH(16), .CNT_W(32), .ACC_W(17), .WINDOW(WIN)) dut_sat (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear_s),
        .mon     (ms)
    );

    int     n_checks = 0;
    int     n_err    = 0;
    int     cyc      = 0;
    smp_t   q[$];
    longint last_cnt, last_err, last_max, last_sum;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window statistics from the first WIN accepted samples, plain arithmetic.
    function automatic void model_window(output longint c, output longint e,
                                         output longint mx, output longint sm);
        c = 0; e = 0; mx = 0; sm = 0;
        for (int i = 0; i < WIN && i < q.size(); i++) begin
            longint ex, ap, d;
            ex = longint'(q[i].a) + longint'(q[i].b);
            ap = longint'(q[i].ap);
            d  = (ex > ap) ? ex - ap : ap - ex;
            c++;
            if (d != 0) e++;
            if (d > mx) mx = d;
            sm += d;
        end
    endfunction

    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] ap, input bit rr, input bit clr, output bit acc);
        longint c, e, mx, sm;
        smp_t   s;
        c = 0; e = 0; mx = 0; sm = 0;
        @(negedge clk);
        cyc++;
        acc = 1'b0;
        if (m.report_valid) begin
            check_eq("rpt_window_full", 64'(q.size() >= WIN), 64'd1);
            model_window(c, e, mx, sm);
            check_eq("rpt_cnt", m.sample_cnt, c);
            check_eq("rpt_err", m.err_cnt, e);
            check_eq("rpt_max", m.max_ed, mx);
            check_eq("rpt_sum", m.sum_ed, sm);
        end else begin
            check_eq("hold_cnt", m.sample_cnt, last_cnt);
            check_eq("hold_err", m.err_cnt, last_err);
            check_eq("hold_max", m.max_ed, last_max);
            check_eq("hold_sum", m.sum_ed, last_sum);
        end
        m.valid        = v;
        m.add1         = a;
        m.add2         = b;
        m.approx       = ap;
        m.report_ready = rr;
        clear          = clr;
        if (clr) begin
            q.delete();
            last_cnt = 0; last_err = 0; last_max = 0; last_sum = 0;
        end else begin
            if (m.report_valid && rr) begin
                last_cnt = c; last_err = e; last_max = mx; last_sum = sm;
                for (int i = 0; i < WIN; i++) begin
                    if (q.size() > 0) void'(q.pop_front());
                end
            end
            if (v && m.ready) begin
                s.a = a; s.b = b; s.ap = ap;
                q.push_back(s);
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit rr);
        bit acc;
        step(1'b0, 16'h0, 16'h0, 17'h0, rr, 1'b0, acc);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            step(1'b1, a, b, ap, 1'b0, 1'b0, acc);
            n++;
        end
        check_eq("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic send_exact();
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        send(a, b, 17'(a) + 17'(b));
    endtask

    task automatic wait_report();
        int n;
        n = 0;
        while (!m.report_valid && n < 30) begin
            idle(1'b0);
            n++;
        end
        check_eq("report_seen", 64'(m.report_valid), 64'd1);
    endtask

    task automatic handshake();
        idle(1'b1);
        idle(1'b0);
        check_eq("post_hs_rvalid", 64'(m.report_valid), 64'd0);
        check_eq("post_hs_ready", 64'(m.ready), 64'd1);
    endtask

    task automatic do_clear();
        bit acc;
        step(1'b0, 16'h0, 16'h0, 17'h0, 1'b0, 1'b1, acc);
        idle(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          n_acc;
        int          acc_cyc[$];
        logic [15:0] a, b;
        logic [16:0] ex, ap;
        longint      sat_exp;

        m.valid = 1'b0; m.add1 = '0; m.add2 = '0; m.approx = '0; m.report_ready = 1'b0;
        ms.valid = 1'b0; ms.add1 = '0; ms.add2 = '0; ms.approx = '0; ms.report_ready = 1'b0;
        clear = 1'b0; clear_s = 1'b0; rst_n = 1'b0;
        last_cnt = 0; last_err = 0; last_max = 0; last_sum = 0;

        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_ready", 64'(m.ready), 64'd1);
        check_eq("rst_rvalid", 64'(m.report_valid), 64'd0);
        check_eq("rst_cnt", m.sample_cnt, 64'd0);
        check_eq("rst_err", m.err_cnt, 64'd0);
        check_eq("rst_max", m.max_ed, 64'd0);
        check_eq("rst_sum", m.sum_ed, 64'd0);

        // Window of exact samples
        send(16'h29AF, 16'h7A1B, 17'h0A3CA);
        send(16'h1100, 16'h1111, 17'h02211);
        send(16'h5555, 16'hAAAA, 17'h0FFFF);
        send(16'h0000, 16'h0000, 17'h00000);
        wait_report();
        check_eq("t1_cnt", m.sample_cnt, 64'd4);
        check_eq("t1_err", m.err_cnt, 64'd0);
        check_eq("t1_max", m.max_ed, 64'd0);
        check_eq("t1_sum", m.sum_ed, 64'd0);
        handshake();

        // Two erroneous samples, including the largest exact sum
        send(16'h29AF, 16'h7A1B, 17'h0A2CA);
        send(16'h8943, 16'hFFFF, 17'h08942);
        send(16'h1234, 16'h4321, 17'h05555);
        send(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        wait_report();
        check_eq("t2_cnt", m.sample_cnt, 64'd4);
        check_eq("t2_err", m.err_cnt, 64'd2);
        check_eq("t2_max", m.max_ed, 64'h10000);
        check_eq("t2_sum", m.sum_ed, 64'h10100);
        handshake();

        // valid held high for 10 cycles while the consumer stalls
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            step(1'b1, a, b, 17'(a) + 17'($urandom_range(0, 3)), 1'b0, 1'b0, acc);
            if (acc) n_acc++;
        end
        idle(1'b0);
        check_eq("t3_accepts", 64'(n_acc), 64'd4);
        check_eq("t3_ready_low", 64'(m.ready), 64'd0);
        check_eq("t3_rvalid", 64'(m.report_valid), 64'd1);
        idle(1'b0);
        check_eq("t3_ready_still_low", 64'(m.ready), 64'd0);
        handshake();

        // Clear after two samples; the sample alongside clear is dropped
        send(16'h1000, 16'h0001, 17'h00000);
        send(16'hFFFF, 16'h0000, 17'h1FFFF);
        step(1'b1, 16'hAAAA, 16'h0001, 17'h00000, 1'b0, 1'b1, acc);
        idle(1'b0);
        check_eq("t4_clr_rvalid", 64'(m.report_valid), 64'd0);
        check_eq("t4_clr_ready", 64'(m.ready), 64'd1);
        repeat (4) send_exact();
        wait_report();
        check_eq("t4_cnt", m.sample_cnt, 64'd4);
        check_eq("t4_err", m.err_cnt, 64'd0);
        check_eq("t4_sum", m.sum_ed, 64'd0);
        handshake();

        // Back-to-back windows with report_ready held high
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            step(1'b1, a, b, 17'($urandom), 1'b1, 1'b0, acc);
            if (acc) acc_cyc.push_back(cyc);
        end
        check_eq("turnaround", (acc_cyc.size() >= 5) ? 64'(acc_cyc[4] - acc_cyc[0]) : 64'd0,
                 64'(WIN + 4));
        do_clear();

        // Random traffic with valid gaps and random consumer stalls
        for (int i = 0; i < 300; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ex = 17'(a) + 17'(b);
            case ($urandom_range(0, 2))
                0:       ap = ex;
                1:       ap = ex ^ (17'd1 << $urandom_range(0, 16));
                default: ap = 17'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, a, b, ap, $urandom_range(0, 1) == 1, 1'b0, acc);
        end
        do_clear();

        // Asynchronous reset in the middle of a report
        repeat (4) send(16'h0100, 16'h0001, 17'h00000);
        wait_report();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rvalid", 64'(m.report_valid), 64'd0);
        check_eq("t5_ready", 64'(m.ready), 64'd1);
        check_eq("t5_cnt", m.sample_cnt, 64'd0);
        check_eq("t5_err", m.err_cnt, 64'd0);
        check_eq("t5_max", m.max_ed, 64'd0);
        check_eq("t5_sum", m.sum_ed, 64'd0);
        q.delete();
        last_cnt = 0; last_err = 0; last_max = 0; last_sum = 0;
        m.valid = 1'b0; m.report_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);

        // Saturating sum on the ACC_W=17 build
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            check_eq("sat_ready", 64'(ms.ready), 64'd1);
            ms.valid = 1'b1; ms.add1 = 16'h0; ms.add2 = 16'h0; ms.approx = 17'h1FFFF;
        end
        @(negedge clk);
        ms.valid = 1'b0;
        n_acc = 0;
        while (!ms.report_valid && n_acc < 30) begin
            @(negedge clk);
            n_acc++;
        end
        sat_exp = longint'(WIN) * 64'h1FFFF;
        if (sat_exp > 64'h1FFFF) sat_exp = 64'h1FFFF;
        check_eq("sat_seen", 64'(ms.report_valid), 64'd1);
        check_eq("sat_sum", ms.sum_ed, sat_exp);
        check_eq("sat_max", ms.max_ed, 64'h1FFFF);
        check_eq("sat_cnt", ms.sample_cnt, 64'(WIN));
        check_eq("sat_err", ms.err_cnt, 64'(WIN));
        ms.report_ready = 1'b1;
        @(negedge clk);
        ms.report_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
